// File: rtl/data_m_initiator.sv
// data_m_initiator
//   Bus initiator for the data_m peripheral bus. Takes one command at a time from a
//   host-side source, holds data_m_access until the responder acks, captures read data
//   and returns exactly one response pulse per command.
//
//   Optional feature: define DATA_M_INITIATOR_TIMEOUT_EN to abort an access that has
//   not been acked within TIMEOUT_CYCLES cycles. The abort returns rsp_error=1 and
//   rsp_data=16'hFFFF. Without the macro the initiator waits for ack indefinitely and
//   rsp_error is tied low.
//
// Ports
//   clk, reset_n                system clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_wr, cmd_addr, cmd_data, cmd_bytesel   command payload
//   rsp_valid, rsp_data, rsp_error            one-cycle response (no backpressure)
//   data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel  bus outputs
//   data_m_data_in, data_m_ack                bus inputs from the responder
module data_m_initiator #(
   parameter int unsigned ADDR_W         = 19,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [15:0]       cmd_data,
   input  logic [1:0]        cmd_bytesel,
   output logic              rsp_valid,
   output logic [15:0]       rsp_data,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] data_m_addr,
   output logic [15:0]       data_m_data_out,
   input  logic [15:0]       data_m_data_in,
   output logic              data_m_access,
   output logic              data_m_wr_en,
   output logic [1:0]        data_m_bytesel,
   input  logic              data_m_ack
);

   typedef enum logic [1:0] {StIdle, StAccess, StTurn} state_e;

   state_e state_q;

   // Gated by reset_n so no command is accepted while reset is asserted.
   assign cmd_ready = (state_q == StIdle) & reset_n;

`ifdef DATA_M_INITIATOR_TIMEOUT_EN
   localparam int unsigned     CntW     = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] tmo_cnt_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign rsp_error      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= StIdle;
         data_m_access   <= 1'b0;
         data_m_wr_en    <= 1'b0;
         data_m_bytesel  <= 2'b00;
         data_m_addr     <= '0;
         data_m_data_out <= 16'h0000;
         rsp_valid       <= 1'b0;
         rsp_data        <= 16'h0000;
`ifdef DATA_M_INITIATOR_TIMEOUT_EN
         rsp_error       <= 1'b0;
         tmo_cnt_q       <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  data_m_addr     <= cmd_addr;
                  data_m_data_out <= cmd_data;
                  data_m_bytesel  <= cmd_bytesel;
                  data_m_wr_en    <= cmd_wr;
                  data_m_access   <= 1'b1;
                  state_q         <= StAccess;
`ifdef DATA_M_INITIATOR_TIMEOUT_EN
                  tmo_cnt_q       <= '0;
`endif
               end
            end
            StAccess: begin
               // Ack takes priority over the timeout limit in the same cycle.
               if (data_m_ack) begin
                  data_m_access  <= 1'b0;
                  data_m_wr_en   <= 1'b0;
                  data_m_bytesel <= 2'b00;
                  rsp_valid      <= 1'b1;
                  rsp_data       <= data_m_wr_en ? 16'h0000 : data_m_data_in;
                  state_q        <= StTurn;
`ifdef DATA_M_INITIATOR_TIMEOUT_EN
                  rsp_error      <= 1'b0;
`endif
               end
`ifdef DATA_M_INITIATOR_TIMEOUT_EN
               else if (tmo_cnt_q == CntLimit) begin
                  data_m_access  <= 1'b0;
                  data_m_wr_en   <= 1'b0;
                  data_m_bytesel <= 2'b00;
                  rsp_valid      <= 1'b1;
                  rsp_data       <= 16'hFFFF;
                  rsp_error      <= 1'b1;
                  state_q        <= StTurn;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CntW'(1);
               end
`endif
            end
            // One dead cycle: the responder saw access on the ack edge and may re-ack.
            StTurn: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_m_initiator.sv
module tb_data_m_initiator;

   localparam int unsigned AW = 19;

   logic          clk;
   logic          reset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [15:0]   cmd_data;
   logic [1:0]    cmd_bytesel;
   logic          rsp_valid;
   logic [15:0]   rsp_data;
   logic          rsp_error;
   logic [AW-1:0] data_m_addr;
   logic [15:0]   data_m_data_out;
   logic [15:0]   data_m_data_in;
   logic          data_m_access;
   logic          data_m_wr_en;
   logic [1:0]    data_m_bytesel;
   logic          data_m_ack;

   int n_tests = 0;
   int n_fail  = 0;

   data_m_initiator #(
      .ADDR_W        (AW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_wr         (cmd_wr),
      .cmd_addr       (cmd_addr),
      .cmd_data       (cmd_data),
      .cmd_bytesel    (cmd_bytesel),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_error      (rsp_error),
      .data_m_addr    (data_m_addr),
      .data_m_data_out(data_m_data_out),
      .data_m_data_in (data_m_data_in),
      .data_m_access  (data_m_access),
      .data_m_wr_en   (data_m_wr_en),
      .data_m_bytesel (data_m_bytesel),
      .data_m_ack     (data_m_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register responder: acks cfg_delay cycles after access is first seen
   // (0 = never acks); with cfg_reack it acks once more on the following edge.
   int          cfg_delay = 1;
   bit          cfg_reack = 0;
   int          resp_cnt  = 0;
   int          n_acks    = 0;
   logic [15:0] mem [16];
   // Reference contents the bench expects the responder to hold.
   logic [15:0] model [16];

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]   = 16'h0000;
         model[i] = 16'h0000;
      end
      data_m_ack     = 1'b0;
      data_m_data_in = 16'h0000;
   end

   always @(posedge clk) begin
      if (data_m_access) begin
         if (cfg_delay != 0 && resp_cnt == cfg_delay - 1) begin
            data_m_ack <= 1'b1;
            n_acks     <= n_acks + 1;
            data_m_data_in <= mem[data_m_addr[3:0]];
            if (data_m_wr_en) begin
               if (data_m_bytesel[0]) mem[data_m_addr[3:0]][7:0]  <= data_m_data_out[7:0];
               if (data_m_bytesel[1]) mem[data_m_addr[3:0]][15:8] <= data_m_data_out[15:8];
            end
         end else if (cfg_reack && cfg_delay != 0 && resp_cnt == cfg_delay) begin
            data_m_ack <= 1'b1;
         end else begin
            data_m_ack <= 1'b0;
         end
         resp_cnt <= resp_cnt + 1;
      end else begin
         data_m_ack <= 1'b0;
         resp_cnt   <= 0;
      end
   end

   task automatic model_write(input logic [3:0] i, input logic [15:0] d, input logic [1:0] be);
      logic [15:0] mask;
      mask = {{8{be[1]}}, {8{be[0]}}};
      model[i] = (model[i] & ~mask) | (d & mask);
   endtask

   // Issues one command and observes it; starts and ends on a negedge.
   task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [1:0] be, input int dly, input bit reack,
                          output logic [15:0] rdata, output logic rerr, output int nrsp,
                          output int acc_cyc, output bit stable, output int rsp_idx,
                          output int rdy_idx, output bit tout);
      int guard;
      nrsp = 0; acc_cyc = 0; stable = 1; rsp_idx = -1; rdy_idx = -1; tout = 0;
      rdata = 16'hxxxx; rerr = 1'bx;
      cfg_delay = dly;
      cfg_reack = reack;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_bytesel = be;
      @(posedge clk);
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (c == 0) cmd_valid = 1'b0;
         if (data_m_access) begin
            acc_cyc++;
            if (data_m_addr !== a || data_m_data_out !== d || data_m_bytesel !== be ||
                data_m_wr_en !== wr) stable = 0;
         end
         if (rsp_valid) begin
            nrsp++;
            if (rsp_idx < 0) begin
               rsp_idx = c;
               rdata   = rsp_data;
               rerr    = rsp_error;
            end
         end
         if (nrsp > 0 && cmd_ready && rdy_idx < 0) rdy_idx = c;
         if (rdy_idx >= 0 && c >= rdy_idx + 2) break;
      end
      if (rdy_idx < 0) tout = 1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = 16'h0; cmd_bytesel = 2'b00;
      #1 reset_n = 1'b0;
      #2;
      n_tests++;
      if ({data_m_access, data_m_wr_en, data_m_bytesel, rsp_valid, rsp_error, cmd_ready}
          !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got acc=%b wr=%b be=%b rv=%b re=%b rdy=%b want all 0",
                  data_m_access, data_m_wr_en, data_m_bytesel, rsp_valid, rsp_error, cmd_ready);
      end
      n_tests++;
      if (data_m_addr !== '0 || data_m_data_out !== 16'h0 || rsp_data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h dout=%h rdata=%h want 0",
                  data_m_addr, data_m_data_out, rsp_data);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_led();
      logic [15:0] rd; logic re; int nr, ac, ri, ki, a0; bit st, to;
      a0 = n_acks;
      run_cmd(1'b1, 19'h00010, 16'h1234, 2'b11, 1, 0, rd, re, nr, ac, st, ri, ki, to);
      model_write(4'h0, 16'h1234, 2'b11);
      n_tests++;
      if (to || ac != 2 || nr != 1 || rd !== 16'h0 || re !== 1'b0) begin
         n_fail++;
         $display("FAIL led_write: got to=%0d acc=%0d nrsp=%0d rdata=%h err=%b want 0/2/1/0000/0",
                  to, ac, nr, rd, re);
      end
      n_tests++;
      if (ri != 2 || ki != 3 || n_acks - a0 != 1) begin
         n_fail++;
         $display("FAIL led_latency: got rsp@%0d ready@%0d acks=%0d want 2/3/1",
                  ri, ki, n_acks - a0);
      end
      n_tests++;
      if (mem[0] !== model[0]) begin
         n_fail++;
         $display("FAIL led_value: got %h want %h", mem[0], model[0]);
      end
      run_cmd(1'b1, 19'h00010, 16'hABCD, 2'b10, 1, 0, rd, re, nr, ac, st, ri, ki, to);
      model_write(4'h0, 16'hABCD, 2'b10);
      n_tests++;
      if (mem[0] !== 16'hAB34 || model[0] !== 16'hAB34) begin
         n_fail++;
         $display("FAIL led_hi_byte: got %h want AB34", mem[0]);
      end
      run_cmd(1'b0, 19'h00010, 16'h0000, 2'b11, 1, 0, rd, re, nr, ac, st, ri, ki, to);
      n_tests++;
      if (to || nr != 1 || rd !== 16'hAB34 || re !== 1'b0) begin
         n_fail++;
         $display("FAIL led_read: got to=%0d nrsp=%0d rdata=%h err=%b want 0/1/AB34/0",
                  to, nr, rd, re);
      end
   endtask

   task automatic test_slow_ack();
      logic [15:0] rd; logic re; int nr, ac, ri, ki; bit st, to;
      run_cmd(1'b1, 19'h00013, 16'h5A5A, 2'b01, 5, 1, rd, re, nr, ac, st, ri, ki, to);
      model_write(4'h3, 16'h5A5A, 2'b01);
      n_tests++;
      if (to || !st || ac != 6 || nr != 1 || ri != 6) begin
         n_fail++;
         $display("FAIL slow_ack: got to=%0d stable=%0d acc=%0d nrsp=%0d rsp@%0d want 0/1/6/1/6",
                  to, st, ac, nr, ri);
      end
      n_tests++;
      if (mem[3] !== model[3]) begin
         n_fail++;
         $display("FAIL slow_ack_value: got %h want %h", mem[3], model[3]);
      end
   endtask

   task automatic test_random();
      logic [15:0] rd, d, exp; logic re, wr; logic [3:0] i; logic [1:0] be;
      int nr, ac, ri, ki, dly; bit st, to, rk;
      for (int n = 0; n < 20; n++) begin
         wr  = 1'($urandom % 2);
         i   = 4'($urandom % 16);
         d   = 16'($urandom);
         be  = 2'($urandom % 4);
         dly = $urandom_range(1, 4);
         rk  = 1'($urandom % 2);
         exp = wr ? 16'h0000 : model[i];
         run_cmd(wr, 19'h00010 + 19'(i), d, be, dly, rk, rd, re, nr, ac, st, ri, ki, to);
         if (wr) model_write(i, d, be);
         n_tests++;
         if (to || nr != 1 || rd !== exp || re !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_rsp[%0d]: got to=%0d nrsp=%0d rdata=%h err=%b want 0/1/%h/0",
                     n, to, nr, rd, re, exp);
         end
         n_tests++;
         if (!st || ac != dly + 1 || ri != dly + 1 || ki != dly + 2) begin
            n_fail++;
            $display("FAIL rand_bus[%0d]: got stable=%0d acc=%0d rsp@%0d rdy@%0d dly=%0d",
                     n, st, ac, ri, ki, dly);
         end
         n_tests++;
         if (mem[i] !== model[i]) begin
            n_fail++;
            $display("FAIL rand_mem[%0d]: got %h want %h", n, mem[i], model[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic          c_wr [3];
      logic [AW-1:0] c_a  [3];
      logic [15:0]   c_d  [3];
      logic [1:0]    c_be [3];
      logic [15:0]   exp  [3];
      logic [15:0]   got  [$];
      int            acc  [3];
      int            k, a0;
      bit            take;
      c_wr[0] = 1'b1; c_a[0] = 19'h00011; c_d[0] = 16'h1111; c_be[0] = 2'b11;
      c_wr[1] = 1'b1; c_a[1] = 19'h00012; c_d[1] = 16'h2222; c_be[1] = 2'b01;
      c_wr[2] = 1'b0; c_a[2] = 19'h00011; c_d[2] = 16'h0000; c_be[2] = 2'b11;
      model_write(4'h1, 16'h1111, 2'b11);
      model_write(4'h2, 16'h2222, 2'b01);
      exp[0] = 16'h0000; exp[1] = 16'h0000; exp[2] = model[1];
      for (int j = 0; j < 3; j++) acc[j] = -1;
      cfg_delay = 1; cfg_reack = 0;
      a0 = n_acks;
      k = 0;
      cmd_valid = 1'b1; cmd_wr = c_wr[0]; cmd_addr = c_a[0]; cmd_data = c_d[0];
      cmd_bytesel = c_be[0];
      for (int c = 0; c < 30; c++) begin
         if (rsp_valid) got.push_back(rsp_data);
         take = 0;
         if (k < 3 && cmd_valid && cmd_ready) begin
            acc[k] = c;
            k++;
            take = 1;
         end
         @(negedge clk);
         if (take) begin
            if (k < 3) begin
               cmd_wr = c_wr[k]; cmd_addr = c_a[k]; cmd_data = c_d[k]; cmd_bytesel = c_be[k];
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid = 1'b0;
      n_tests++;
      if (k != 3 || acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
         n_fail++;
         $display("FAIL b2b_ready: got accepts=%0d at %0d,%0d,%0d want 3 spaced by 4",
                  k, acc[0], acc[1], acc[2]);
      end
      n_tests++;
      if (got.size() != 3 || n_acks - a0 != 3) begin
         n_fail++;
         $display("FAIL b2b_count: got rsp=%0d acks=%0d want 3/3", got.size(), n_acks - a0);
      end else begin
         for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (got[j] !== exp[j]) begin
               n_fail++;
               $display("FAIL b2b_rsp[%0d]: got %h want %h", j, got[j], exp[j]);
            end
         end
      end
      n_tests++;
      if (mem[1] !== model[1] || mem[2] !== model[2]) begin
         n_fail++;
         $display("FAIL b2b_mem: got %h %h want %h %h", mem[1], mem[2], model[1], model[2]);
      end
   endtask

`ifdef DATA_M_INITIATOR_TIMEOUT_EN
   task automatic test_timeout();
      logic [15:0] rd; logic re; int nr, ac, ri, ki; bit st, to;
      run_cmd(1'b1, 19'h00015, 16'h5555, 2'b11, 0, 0, rd, re, nr, ac, st, ri, ki, to);
      n_tests++;
      if (to || ac != 8 || nr != 1 || rd !== 16'hFFFF || re !== 1'b1 || ri != 8) begin
         n_fail++;
         $display("FAIL timeout: got to=%0d acc=%0d nrsp=%0d rdata=%h err=%b rsp@%0d",
                  to, ac, nr, rd, re, ri);
      end
      run_cmd(1'b0, 19'h00015, 16'h0000, 2'b11, 1, 0, rd, re, nr, ac, st, ri, ki, to);
      n_tests++;
      if (to || nr != 1 || rd !== model[5] || re !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_next: got nrsp=%0d rdata=%h err=%b want 1/%h/0",
                  nr, rd, re, model[5]);
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [15:0] rd; logic re; int nr, ac, ri, ki, guard, seen; bit st, to;
      cfg_delay = 0; cfg_reack = 0;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 19'h00017; cmd_data = 16'hDEAD;
      cmd_bytesel = 2'b11;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (data_m_access !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got access=%b want 1", data_m_access);
      end
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if (data_m_access !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_async: got acc=%b rv=%b rdy=%b want 0/0/0",
                  data_m_access, rsp_valid, cmd_ready);
      end
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      reset_n = 1'b1;
      @(negedge clk);
      if (rsp_valid) seen++;
      n_tests++;
      if (seen != 0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_release: got rsp=%0d ready=%b want 0/1", seen, cmd_ready);
      end
      run_cmd(1'b1, 19'h00017, 16'h0F0F, 2'b11, 2, 0, rd, re, nr, ac, st, ri, ki, to);
      model_write(4'h7, 16'h0F0F, 2'b11);
      n_tests++;
      if (to || nr != 1 || rd !== 16'h0 || mem[7] !== model[7]) begin
         n_fail++;
         $display("FAIL rst_mid_after: got nrsp=%0d rdata=%h mem=%h want 1/0000/%h",
                  nr, rd, mem[7], model[7]);
      end
   endtask

   initial begin
      test_reset();
      test_led();
      test_slow_ack();
      test_back_to_back();
      test_random();
`ifdef DATA_M_INITIATOR_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
